// File: rtl/pco_pkg.sv
// Shared definitions for the front-panel/CPU controller slice:
// cpustate encodings and the program-loader FSM state constants.
package pco_pkg;

    localparam logic [1:0] CS_IDLE  = 2'b00;
    localparam logic [1:0] CS_LOAD  = 2'b01;
    localparam logic [1:0] CS_CHECK = 2'b10;
    localparam logic [1:0] CS_RUN   = 2'b11;

    localparam int unsigned ADDR_W_DEF = 16;

    typedef logic [2:0] ld_state_t;

    localparam ld_state_t LD_IDLE    = 3'd0;
    localparam ld_state_t LD_ARMED   = 3'd1;
    localparam ld_state_t LD_WRITE   = 3'd2;
    localparam ld_state_t LD_READ    = 3'd3;
    localparam ld_state_t LD_CHECK   = 3'd4;
    localparam ld_state_t LD_RELEASE = 3'd5;

endpackage

// File: rtl/prog_loader_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a stability counter.
// Produces the debounced level and a one-cycle pulse on its rising edge.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        // Count only consecutive samples that disagree with the held level.
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/prog_loader.sv
// Front-panel program loader: writes the switch byte to an auto-incrementing
// address on each debounced key press while in LOAD, then verifies by readback.
module prog_loader
    import pco_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cpustate,
    input  logic              key,
    input  logic [7:0]        D,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data_out,
    output logic              write,
    output logic              read,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    logic deb_level, deb_rise;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk    (clk),
        .rst    (rst),
        .key_i  (key),
        .level_o(deb_level),
        .rise_o (deb_rise)
    );

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    logic              in_load;

    assign in_load = (cpustate == CS_LOAD);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        err_d   = err_q;
        eaddr_d = eaddr_q;
        // Leaving LOAD aborts from any active state; pointer and error info are kept.
        if (!in_load) begin
            state_d = LD_IDLE;
        end else begin
            case (state_q)
                LD_IDLE: begin
                    addr_d  = '0;
                    err_d   = 1'b0;
                    eaddr_d = '0;
                    state_d = LD_ARMED;
                end
                LD_ARMED: begin
                    if (deb_rise) begin
                        dout_d  = D;
                        state_d = LD_WRITE;
                    end
                end
                LD_WRITE:   state_d = LD_READ;
                LD_READ:    state_d = LD_CHECK;
                LD_CHECK: begin
                    if ((data_in != dout_q) && !err_q) begin
                        err_d   = 1'b1;
                        eaddr_d = addr_q;
                    end
                    addr_d  = addr_q + 1'b1;
                    state_d = LD_RELEASE;
                end
                LD_RELEASE: begin
                    if (!deb_level) begin
                        state_d = LD_ARMED;
                    end
                end
                default:    state_d = LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            eaddr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            eaddr_q <= eaddr_d;
        end
    end

    // Strobes are gated by cpustate so they drop in the same cycle LOAD is left.
    assign write    = (state_q == LD_WRITE) && in_load;
    assign read     = (state_q == LD_READ) && in_load;
    assign busy     = (state_q != LD_IDLE) && (state_q != LD_ARMED);
    assign addr     = addr_q;
    assign data_out = dout_q;
    assign err      = err_q;
    assign err_addr = eaddr_q;

endmodule
